// File: rtl/riscv_i32_trace_capture_pkg.sv
// Shared encodings for the RISC-V i32 trace capture slice: controller states,
// record kinds and record field layout.
package riscv_i32_trace_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_STOPPED = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    KIND_START  = 2'b00,
    KIND_BRANCH = 2'b01,
    KIND_TRAP   = 2'b10,
    KIND_RSVD   = 2'b11
  } kind_e;

  localparam int unsigned REC_PC_MSB   = 31;
  localparam int unsigned REC_PC_LSB   = 2;
  localparam int unsigned REC_KIND_MSB = 1;
  localparam int unsigned REC_KIND_LSB = 0;

  // Record = word-aligned PC in the upper bits, kind in the low two bits.
  function automatic logic [31:0] make_record(input logic [29:0] pc_word, input kind_e kind);
    logic [31:0] rec;
    rec = '0;
    rec[REC_PC_MSB:REC_PC_LSB]     = pc_word;
    rec[REC_KIND_MSB:REC_KIND_LSB] = kind;
    return rec;
  endfunction

endpackage

// File: rtl/riscv_i32_trace_fifo.sv
// Register-array circular buffer for trace records with push/pop/clear,
// full flag and occupancy count (DEPTH_LOG2+1 bits so full is distinct).
module riscv_i32_trace_fifo
  import riscv_i32_trace_capture_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_clear,
  input  logic [31:0]           i_data,
  output logic [31:0]           o_data,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_pop;
  logic                  w_do_push;

  assign o_full    = (r_count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign w_do_pop  = i_pop & (r_count != '0);
  // A pop in the same cycle frees the slot, so a push into a full buffer lands.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/riscv_i32_trace_capture.sv
// Trace capture controller: arm/trigger/capture FSM compressing retires to
// START/BRANCH/TRAP records. Define RISCV_TRACE_CAPTURE_WRAP_EN to overwrite
// the oldest record on full instead of stopping.
module riscv_i32_trace_capture
  import riscv_i32_trace_capture_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  riscv_clk_enable,
  input  logic                  trace__instr_valid,
  input  logic [31:0]           trace__instr_pc,
  input  logic                  trace__branch_taken,
  input  logic [31:0]           trace__branch_target,
  input  logic                  trace__trap,
  input  logic                  ctrl_start,
  input  logic                  ctrl_stop,
  input  logic                  ctrl_clear,
  input  logic                  trigger_enable,
  input  logic [31:0]           trigger_pc,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [31:0]           rd_data,
  output logic [1:0]            status_state,
  output logic [DEPTH_LOG2:0]   status_count,
  output logic                  status_overflow
);

  state_e      r_state;
  state_e      w_next_state;
  logic        r_first;
  logic        w_next_first;
  logic        r_overflow;
  logic        w_qual;
  logic        w_trig_hit;
  logic        w_rd_pop;
  logic        w_rec_valid;
  logic [31:0] w_rec_data;
  logic        w_full;
  logic        w_full_drop;
  logic        w_push;
  logic        w_pop;
  logic        w_unused_trig;

  assign w_qual        = riscv_clk_enable & trace__instr_valid;
  assign w_trig_hit    = (trace__instr_pc[31:2] == trigger_pc[31:2]);
  assign w_unused_trig = ^trigger_pc[1:0];
  assign w_rd_pop      = rd_valid & rd_ready;
  assign w_full_drop   = w_rec_valid & w_full & ~w_rd_pop & ~ctrl_clear;

`ifdef RISCV_TRACE_CAPTURE_WRAP_EN
  assign w_push = w_rec_valid & ~ctrl_clear;
  assign w_pop  = w_rd_pop | w_full_drop;
`else
  assign w_push = w_rec_valid & ~ctrl_clear & ~w_full_drop;
  assign w_pop  = w_rd_pop;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_first    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_first    <= w_next_first;
      if (ctrl_clear)       r_overflow <= 1'b0;
      else if (w_full_drop) r_overflow <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_first = r_first;
    case (r_state)
      ST_IDLE, ST_STOPPED: begin
        if (ctrl_start && !ctrl_stop) begin
          w_next_state = trigger_enable ? ST_ARMED : ST_CAPTURE;
          w_next_first = ~trigger_enable;
        end
      end
      ST_ARMED: begin
        if (ctrl_stop) begin
          w_next_state = ST_STOPPED;
        end else if (w_qual && w_trig_hit) begin
          w_next_state = ST_CAPTURE;
          w_next_first = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (w_qual) w_next_first = 1'b0;
        if (ctrl_stop) w_next_state = ST_STOPPED;
`ifndef RISCV_TRACE_CAPTURE_WRAP_EN
        else if (w_full_drop) w_next_state = ST_STOPPED;
`endif
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // The triggering retire becomes the START record on the edge that leaves ARMED.
  always_comb begin
    w_rec_valid = 1'b0;
    w_rec_data  = '0;
    case (r_state)
      ST_ARMED: begin
        if (w_qual && w_trig_hit && !ctrl_stop) begin
          w_rec_valid = 1'b1;
          w_rec_data  = make_record(trace__instr_pc[31:2], KIND_START);
        end
      end
      ST_CAPTURE: begin
        if (w_qual) begin
          if (r_first) begin
            w_rec_valid = 1'b1;
            w_rec_data  = make_record(trace__instr_pc[31:2], KIND_START);
          end else if (trace__trap) begin
            w_rec_valid = 1'b1;
            w_rec_data  = make_record(trace__instr_pc[31:2], KIND_TRAP);
          end else if (trace__branch_taken) begin
            w_rec_valid = 1'b1;
            w_rec_data  = make_record(trace__branch_target[31:2], KIND_BRANCH);
          end
        end
      end
      default: ;
    endcase
  end

  riscv_i32_trace_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (ctrl_clear),
    .i_data  (w_rec_data),
    .o_data  (rd_data),
    .o_count (status_count),
    .o_full  (w_full)
  );

  assign rd_valid        = (status_count != '0);
  assign status_state    = r_state;
  assign status_overflow = r_overflow;

endmodule

// File: tb/tb_riscv_i32_trace_capture.sv
// Directed self-checking bench for riscv_i32_trace_capture (4-entry buffer).
module tb_riscv_i32_trace_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        riscv_clk_enable;
  logic        trace__instr_valid;
  logic [31:0] trace__instr_pc;
  logic        trace__branch_taken;
  logic [31:0] trace__branch_target;
  logic        trace__trap;
  logic        ctrl_start;
  logic        ctrl_stop;
  logic        ctrl_clear;
  logic        trigger_enable;
  logic [31:0] trigger_pc;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic [1:0]  status_state;
  logic [2:0]  status_count;
  logic        status_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_i32_trace_capture #(
    .DEPTH_LOG2(2)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .riscv_clk_enable    (riscv_clk_enable),
    .trace__instr_valid  (trace__instr_valid),
    .trace__instr_pc     (trace__instr_pc),
    .trace__branch_taken (trace__branch_taken),
    .trace__branch_target(trace__branch_target),
    .trace__trap         (trace__trap),
    .ctrl_start          (ctrl_start),
    .ctrl_stop           (ctrl_stop),
    .ctrl_clear          (ctrl_clear),
    .trigger_enable      (trigger_enable),
    .trigger_pc          (trigger_pc),
    .rd_valid            (rd_valid),
    .rd_ready            (rd_ready),
    .rd_data             (rd_data),
    .status_state        (status_state),
    .status_count        (status_count),
    .status_overflow     (status_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ctrl_start          = 1'b0;
    ctrl_stop           = 1'b0;
    ctrl_clear          = 1'b0;
    trace__instr_valid  = 1'b0;
    trace__branch_taken = 1'b0;
    trace__trap         = 1'b0;
    rd_ready            = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic br, input logic [31:0] tgt, input logic trap);
    trace__instr_valid   = 1'b1;
    trace__instr_pc      = pc;
    trace__branch_taken  = br;
    trace__branch_target = tgt;
    trace__trap          = trap;
    step();
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    chk(tag, rd_data, exp);
    rd_ready = 1'b1;
    step();
  endtask

  initial begin
    reset_n = 1'b0; riscv_clk_enable = 1'b1; trace__instr_valid = 1'b0;
    trace__instr_pc = '0; trace__branch_taken = 1'b0; trace__branch_target = '0;
    trace__trap = 1'b0; ctrl_start = 1'b0; ctrl_stop = 1'b0; ctrl_clear = 1'b0;
    trigger_enable = 1'b0; trigger_pc = '0; rd_ready = 1'b0;
    #12;
    chk("rst_state", {30'd0, status_state}, 32'd0);
    chk("rst_count", {29'd0, status_count}, 32'd0);
    chk("rst_ovf", {31'd0, status_overflow}, 32'd0);
    chk("rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_data", rd_data, 32'd0);
    reset_n = 1'b1;
    step();

    // Basic capture without trigger
    ctrl_start = 1'b1; step();
    chk("start_state", {30'd0, status_state}, 32'd2);
    retire(32'h100, 1'b0, 32'h0, 1'b0);
    chk("lat_count", {29'd0, status_count}, 32'd1);
    chk("lat_valid", {31'd0, rd_valid}, 32'd1);
    retire(32'h104, 1'b1, 32'h200, 1'b0);
    retire(32'h200, 1'b0, 32'h0, 1'b1);
    chk("basic_count", {29'd0, status_count}, 32'd3);
    riscv_clk_enable = 1'b0;
    retire(32'h204, 1'b1, 32'h900, 1'b0);
    riscv_clk_enable = 1'b1;
    chk("unqual_count", {29'd0, status_count}, 32'd3);
    chk("hold_data", rd_data, 32'h00000100);
    pop_chk("basic_r0", 32'h00000100);
    pop_chk("basic_r1", 32'h00000201);
    pop_chk("basic_r2", 32'h00000202);
    chk("drained_valid", {31'd0, rd_valid}, 32'd0);
    ctrl_stop = 1'b1; step();
    chk("stop_state", {30'd0, status_state}, 32'd3);

    // Trigger on 0x300 (low bits of trigger_pc ignored)
    trigger_enable = 1'b1; trigger_pc = 32'h302;
    ctrl_start = 1'b1; step();
    chk("armed_state", {30'd0, status_state}, 32'd1);
    retire(32'h100, 1'b0, 32'h0, 1'b0);
    retire(32'h104, 1'b1, 32'h500, 1'b0);
    chk("armed_count", {29'd0, status_count}, 32'd0);
    chk("armed_hold", {30'd0, status_state}, 32'd1);
    retire(32'h300, 1'b1, 32'h500, 1'b0);
    chk("trig_state", {30'd0, status_state}, 32'd2);
    chk("trig_count", {29'd0, status_count}, 32'd1);
    pop_chk("trig_rec", 32'h00000300);
    ctrl_stop = 1'b1; step();
    trigger_enable = 1'b0;

    // Fill past capacity
    ctrl_start = 1'b1; step();
    retire(32'h10, 1'b1, 32'h1000, 1'b0);
    retire(32'h14, 1'b1, 32'h2000, 1'b0);
    retire(32'h18, 1'b1, 32'h3000, 1'b0);
    retire(32'h1C, 1'b1, 32'h4000, 1'b0);
    chk("fill_ovf0", {31'd0, status_overflow}, 32'd0);
    retire(32'h20, 1'b1, 32'h5000, 1'b0);
    chk("full_count", {29'd0, status_count}, 32'd4);
    chk("full_ovf", {31'd0, status_overflow}, 32'd1);
`ifdef RISCV_TRACE_CAPTURE_WRAP_EN
    chk("full_state", {30'd0, status_state}, 32'd2);
    chk("full_oldest", rd_data, 32'h00002001);
    retire(32'h24, 1'b1, 32'h6000, 1'b0);
    chk("wrap_oldest2", rd_data, 32'h00003001);
`else
    chk("full_state", {30'd0, status_state}, 32'd3);
    chk("full_oldest", rd_data, 32'h00000010);
    retire(32'h24, 1'b1, 32'h6000, 1'b0);
    chk("stopped_oldest", rd_data, 32'h00000010);
`endif
    chk("post_count", {29'd0, status_count}, 32'd4);

    ctrl_clear = 1'b1; step();
    chk("clr_count", {29'd0, status_count}, 32'd0);
    chk("clr_ovf", {31'd0, status_overflow}, 32'd0);
`ifdef RISCV_TRACE_CAPTURE_WRAP_EN
    chk("clr_state", {30'd0, status_state}, 32'd2);
`else
    chk("clr_state", {30'd0, status_state}, 32'd3);
`endif
    ctrl_stop = 1'b1; step();

    // Full buffer with concurrent pop and write
    ctrl_start = 1'b1; step();
    retire(32'h40, 1'b0, 32'h0, 1'b0);
    retire(32'h44, 1'b1, 32'h800, 1'b0);
    retire(32'h48, 1'b1, 32'h900, 1'b0);
    retire(32'h4C, 1'b1, 32'hA00, 1'b0);
    chk("pf_count", {29'd0, status_count}, 32'd4);
    chk("pf_head", rd_data, 32'h00000040);
    rd_ready = 1'b1;
    retire(32'h50, 1'b1, 32'hB00, 1'b0);
    chk("pw_count", {29'd0, status_count}, 32'd4);
    chk("pw_ovf", {31'd0, status_overflow}, 32'd0);
    chk("pw_state", {30'd0, status_state}, 32'd2);
    pop_chk("pw_r0", 32'h00000801);
    pop_chk("pw_r1", 32'h00000901);
    pop_chk("pw_r2", 32'h00000A01);
    pop_chk("pw_r3", 32'h00000B01);

    // Stop on the same edge as a branch retire
    ctrl_stop = 1'b1;
    retire(32'h54, 1'b1, 32'hC00, 1'b0);
    chk("ss_state", {30'd0, status_state}, 32'd3);
    chk("ss_count", {29'd0, status_count}, 32'd1);
    retire(32'h58, 1'b1, 32'hD00, 1'b0);
    chk("ss_ignored", {29'd0, status_count}, 32'd1);
    pop_chk("ss_rec", 32'h00000C01);

    // Asynchronous reset mid-capture
    ctrl_start = 1'b1; step();
    retire(32'h60, 1'b0, 32'h0, 1'b0);
    retire(32'h64, 1'b1, 32'hE00, 1'b0);
    retire(32'h68, 1'b0, 32'h0, 1'b1);
    chk("ar_pre_count", {29'd0, status_count}, 32'd3);
    #1 reset_n = 1'b0;
    #1;
    chk("ar_count", {29'd0, status_count}, 32'd0);
    chk("ar_valid", {31'd0, rd_valid}, 32'd0);
    chk("ar_state", {30'd0, status_state}, 32'd0);
    chk("ar_data", rd_data, 32'd0);
    reset_n = 1'b1;
    step();
    chk("ar_idle", {30'd0, status_state}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_i32_trace_capture.md
# riscv_i32_trace_capture

Capture controller that sequences recording of RISC-V i32 execution trace into an on-chip circular buffer. Sits beside the core's trace bundle output and compresses the instruction stream to discontinuities only: start point, taken branches and traps. Software or a debug host arms it, optionally waits for a trigger PC, then drains records through a valid/ready read port.

## Interface
- DEPTH_LOG2, 4, log2 of buffer entries (16 x 32-bit records)
- clk  in  1  free-running clock
- reset_n  in  1  reset; asynchronous, active-low
- riscv_clk_enable  in  1  core ticks on this edge; trace inputs qualified by it
- trace__instr_valid  in  1  instruction retires this tick
- trace__instr_pc  in  32  PC of retiring instruction
- trace__branch_taken  in  1  retiring instruction is a taken branch/jump
- trace__branch_target  in  32  target of taken branch
- trace__trap  in  1  retiring instruction trapped
- ctrl_start  in  1  pulse: arm capture
- ctrl_stop  in  1  pulse: end capture
- ctrl_clear  in  1  pulse: empty buffer, clear overflow
- trigger_enable  in  1  wait for trigger_pc before capturing
- trigger_pc  in  32  trigger address (bits 1:0 ignored)
- rd_valid  out  1  record available
- rd_ready  in  1  consumer accepts record
- rd_data  out  32  record: bits 31:2 = PC[31:2], bits 1:0 = kind
- status_state  out  2  controller state
- status_count  out  DEPTH_LOG2+1  records held
- status_overflow  out  1  records lost (sticky)

## Operation
- Kind encoding: 00 START, 01 BRANCH (target address), 10 TRAP (trapping PC), 11 reserved.
- States: IDLE(00), ARMED(01), CAPTURE(10), STOPPED(11). Reset -> IDLE.
- IDLE/STOPPED + ctrl_start: -> ARMED if trigger_enable else CAPTURE.
- ARMED: on a qualified retire (valid & riscv_clk_enable) with instr_pc[31:2]==trigger_pc[31:2] -> CAPTURE; that instruction is the first captured.
- CAPTURE: first qualified retire writes START with instr_pc; subsequent qualified retires write TRAP if trace__trap, else BRANCH if branch_taken, else nothing. First instruction that is also a branch/trap writes only START.
- ctrl_stop in ARMED or CAPTURE -> STOPPED; a retire sampled the same edge is still recorded if in CAPTURE. ctrl_stop has priority over ctrl_start.
- Buffer full during CAPTURE: record dropped, status_overflow set, state -> STOPPED.
- ctrl_clear: pointers and count zeroed, overflow cleared, same edge; state unchanged. Clear beats concurrent write and pop.
- Read: rd_valid = count!=0; rd_data = oldest record; pop on rd_valid & rd_ready.
- Simultaneous write and pop: count unchanged; when full, pop frees space so write succeeds (no overflow).

## Timing
- Reset values: status_state 00, status_count 0, status_overflow 0, rd_valid 0, rd_data 0.
- Record write latency 1: retire sampled on edge N, rd_valid/count reflect it after edge N.
- rd_data combinational from head register; stable while rd_valid & !rd_ready.
- Pointers wrap modulo 2^DEPTH_LOG2; count width DEPTH_LOG2+1 distinguishes full.
- Async reset mid-capture discards all records immediately.

## Configuration
- RISCV_TRACE_CAPTURE_WRAP_EN defined: full buffer overwrites oldest record (read pointer advances, count stays full), status_overflow set, capture continues in CAPTURE.
- Undefined: stop-on-full behaviour as in Operation.

## Structure
- Shared package: kind encodings, state encodings, record field positions.
- Sub-module riscv_i32_trace_fifo: register-array circular buffer with push/pop/clear/full/count; controller holds state machine and record formation.

## Test plan
- Start, no trigger; retires at 0x100 (plain), 0x104 branch to 0x200, 0x200 trap -> records 0x00000100, 0x00000201, 0x00000202; count 3.
- trigger_enable, trigger_pc 0x300; retires 0x100, 0x104, 0x300 -> single START 0x00000300, state CAPTURE.
- DEPTH_LOG2=2, 5 branches, no reads -> 4 records, overflow 1, state STOPPED (WRAP_EN: newest 4 kept, state CAPTURE).
- Full buffer, rd_ready high same edge as branch write -> pop oldest, new record stored, overflow 0, count 4.
- ctrl_stop on same edge as branch retire -> branch recorded, state STOPPED; next retires ignored.
- reset_n low mid-capture with 3 records -> count 0, rd_valid 0, state IDLE asynchronously.
